// File: rtl/seq_mult_sw.sv
// Sequential shift-add multiplier, signed or unsigned per operation, with valid/ready handshakes.
// Optional build macro SEQ_MULT_SW_EARLY_EXIT_EN stops iterating once no multiplier bits remain.
module seq_mult_sw #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic               is_signed,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] product,
   output logic               busy
);

   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {IDLE, RUN, SIGN, DONE} state_t;

   state_t               state, state_nxt;
   logic [2*WIDTH-1:0]   acc;
   logic [2*WIDTH-1:0]   mc;
   logic [WIDTH-1:0]     mb;
   logic [CW-1:0]        cnt;
   logic                 neg;
   logic                 last_iter;

   // The most negative value maps onto 2^(WIDTH-1), which still fits unsigned.
   function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v,
                                                  input logic sgn);
      logic signed [WIDTH-1:0] n;
      n = -v;
      return (sgn && v[WIDTH-1]) ? $unsigned(n) : $unsigned(v);
   endfunction

   function automatic logic [2*WIDTH-1:0] negate(input logic [2*WIDTH-1:0] v);
      return ~v + {{(2*WIDTH-1){1'b0}}, 1'b1};
   endfunction

`ifdef SEQ_MULT_SW_EARLY_EXIT_EN
   assign last_iter = (cnt == CW'(WIDTH - 1)) || (mb[WIDTH-1:1] == '0);
`else
   assign last_iter = (cnt == CW'(WIDTH - 1));
`endif

   assign in_ready = (state == IDLE);
   assign busy     = (state != IDLE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid)  state_nxt = RUN;
         RUN:     if (last_iter) state_nxt = SIGN;
         SIGN:                   state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default:                state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc       <= '0;
         mc        <= '0;
         mb        <= '0;
         cnt       <= '0;
         neg       <= 1'b0;
         product   <= '0;
         out_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  neg <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                  mc  <= {{WIDTH{1'b0}}, magnitude(a, is_signed)};
                  mb  <= magnitude(b, is_signed);
                  acc <= '0;
                  cnt <= '0;
               end
            end
            RUN: begin
               if (mb[0]) acc <= acc + mc;
               mc  <= mc << 1;
               mb  <= mb >> 1;
               cnt <= cnt + CW'(1);
            end
            SIGN: begin
               product   <= neg ? negate(acc) : acc;
               out_valid <= 1'b1;
            end
            DONE: begin
               if (out_ready) out_valid <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_mult_sw.sv
// Directed bench for seq_mult_sw (WIDTH=8): vector table plus backpressure and reset-in-RUN sequences.
module tb_seq_mult_sw;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  a, b;
   logic        is_signed;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] product;
   logic        busy;

   int errors = 0;
   int checks = 0;

   seq_mult_sw #(.WIDTH(8)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .is_signed(is_signed), .out_valid(out_valid),
      .out_ready(out_ready), .product(product), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  a;
      logic [7:0]  b;
      logic        s;
      logic [15:0] p;
   } vec_t;

   vec_t vecs[12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Expected cycles from accept edge to out_valid rising.
   function automatic int exp_lat(input logic [7:0] bv, input logic s);
`ifdef SEQ_MULT_SW_EARLY_EXIT_EN
      logic [7:0] m;
      int k;
      m = (s && bv[7]) ? (~bv + 8'd1) : bv;
      k = 1;
      for (int i = 0; i < 8; i++) if (m[i]) k = i + 1;
      return k + 1;
`else
      return 9;
`endif
   endfunction

   // Accept one operation, wait for out_valid, return cycles since accept edge.
   task automatic start_and_wait(input logic [7:0] av, input logic [7:0] bv, input logic s,
                                 output int cyc);
      @(negedge clk);
      in_valid  = 1'b1;
      a         = av;
      b         = bv;
      is_signed = s;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      a        = 8'hAA;
      b        = 8'h55;
      chk("busy_after_accept", busy, 1'b1);
      chk("in_ready_after_accept", in_ready, 1'b0);
      cyc = 0;
      while (!out_valid && cyc < 40) begin
         @(posedge clk);
         #1;
         cyc++;
      end
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int cyc;
      out_ready = 1'b1;
      start_and_wait(v.a, v.b, v.s, cyc);
      chk($sformatf("latency[%0d]", idx), cyc, exp_lat(v.b, v.s));
      chk($sformatf("product[%0d]", idx), product, v.p);
      @(posedge clk);
      #1;
      chk($sformatf("handshake_ready[%0d]", idx), {out_valid, in_ready}, 2'b01);
   endtask

   initial begin
      int cyc;
      logic [15:0] held;

      vecs[0]  = '{8'hFD, 8'h05, 1'b1, 16'hFFF1};
      vecs[1]  = '{8'h80, 8'h80, 1'b1, 16'h4000};
      vecs[2]  = '{8'h80, 8'h01, 1'b1, 16'hFF80};
      vecs[3]  = '{8'hFF, 8'hFF, 1'b0, 16'hFE01};
      vecs[4]  = '{8'hFF, 8'hFF, 1'b1, 16'h0001};
      vecs[5]  = '{8'h07, 8'h06, 1'b0, 16'h002A};
      vecs[6]  = '{8'h00, 8'hFD, 1'b1, 16'h0000};
      vecs[7]  = '{8'h01, 8'h00, 1'b0, 16'h0000};
      vecs[8]  = '{8'h7F, 8'h81, 1'b1, 16'hC0FF};
      vecs[9]  = '{8'h05, 8'h01, 1'b0, 16'h0005};
      vecs[10] = '{8'hFD, 8'hFB, 1'b0, 16'hF80F};
      vecs[11] = '{8'h80, 8'hFF, 1'b1, 16'h0080};

      reset     = 1'b1;
      in_valid  = 1'b0;
      a         = '0;
      b         = '0;
      is_signed = 1'b0;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_state", {in_ready, out_valid, busy, product}, {3'b100, 16'h0000});
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

      // Backpressure: result held while consumer stalls, new request refused in DONE.
      out_ready = 1'b0;
      start_and_wait(8'h03, 8'h04, 1'b0, cyc);
      chk("bp_latency", cyc, exp_lat(8'h04, 1'b0));
      chk("bp_product", product, 16'h000C);
      held = product;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         in_valid = 1'b1;
         a = 8'h09;
         b = 8'h09;
         @(posedge clk);
         #1;
         chk($sformatf("bp_hold[%0d]", i), {out_valid, in_ready, product}, {2'b10, held});
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk("bp_release", {out_valid, in_ready, busy}, 3'b010);
      repeat (3) @(posedge clk);
      #1;
      chk("bp_no_overlap", {busy, out_valid, product}, {2'b00, held});

      // Reset three cycles into RUN discards the partial result.
      @(negedge clk);
      in_valid  = 1'b1;
      a         = 8'h55;
      b         = 8'h33;
      is_signed = 1'b0;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("pre_reset_busy", busy, 1'b1);
      reset = 1'b1;
      #1;
      chk("mid_reset", {out_valid, in_ready, busy, product}, {3'b010, 16'h0000});
      @(negedge clk);
      reset = 1'b0;
      run_vec('{8'h07, 8'h06, 1'b0, 16'h002A}, 99);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
